// File: rtl/gb_pkg.sv
// Shared types and helpers for ghostbus host-side blocks.
package gb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } gb_state_t;

  // Default park target; must never decode to a real register.
  localparam logic [11:0] GB_PARK_ADDR = 12'hFFF;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/gb_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, with wrap.
module gb_rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   grant,
  output logic            any
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    any   = |req;
    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(last_grant) + 1 + k) % NREQ;
      if (req[idx]) grant = GW'(idx);
    end
  end

endmodule

// File: rtl/gb_host_arbiter.sv
// Round-robin host arbiter sharing one ghostbus port among NREQ requesters.
module gb_host_arbiter
  import gb_pkg::*;
#(
  parameter int             NREQ      = 2,
  parameter int             AW        = 12,
  parameter int             DW        = 32,
  parameter int             RD_LAT    = 1,
  parameter logic [AW-1:0]  PARK_ADDR = AW'(GB_PARK_ADDR)
) (
  input  logic              gb_clk,
  input  logic              gb_rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   resp_valid,
  output logic [DW-1:0]     resp_rdata,
  output logic [AW-1:0]     gb_addr,
  output logic [DW-1:0]     gb_dout,
  output logic              gb_we,
  input  logic [DW-1:0]     gb_din,
  output logic              busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  gb_state_t       state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant;
  logic            any;
  logic [2:0]      cnt;

  gb_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any) req_ready[grant] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      state      <= IDLE;
      gb_addr    <= PARK_ADDR;
      gb_dout    <= '0;
      gb_we      <= 1'b0;
      resp_valid <= '0;
      resp_rdata <= '0;
      last_grant <= GW'(NREQ - 1);
      cnt        <= '0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            gb_addr    <= req_addr[slice_lo(int'(grant), AW) +: AW];
            gb_dout    <= req_wdata[slice_lo(int'(grant), DW) +: DW];
            gb_we      <= req_we[grant];
            last_grant <= grant;
            cnt        <= '0;
            state      <= req_we[grant] ? WR : RD;
          end
        end
        WR: begin
          gb_we                  <= 1'b0;
          gb_addr                <= PARK_ADDR;
          resp_valid[last_grant] <= 1'b1;
          state                  <= IDLE;
        end
        RD: begin
          // Address stays on the bus until the slave's read latency has elapsed.
          if (cnt == 3'(RD_LAT)) begin
            resp_rdata             <= gb_din;
            resp_valid[last_grant] <= 1'b1;
            gb_addr                <= PARK_ADDR;
            state                  <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          gb_we   <= 1'b0;
          gb_addr <= PARK_ADDR;
          state   <= IDLE;
        end
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge gb_clk) $onehot0(req_ready));
  a_resp_onehot:  assert property (@(posedge gb_clk) $onehot0(resp_valid));
  a_we_in_wr:     assert property (@(posedge gb_clk) gb_we |-> state == WR);

endmodule

// File: tb/tb_gb_host_arbiter.sv
// Directed bench for gb_host_arbiter with RD_LAT=1 and RD_LAT=3 instances.
module tb_gb_host_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int HM   = 512;

  logic gb_clk = 1'b0;
  logic gb_rst = 1'b1;

  logic [NREQ-1:0]    req_valid, req_we, req_ready, resp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      resp_rdata, gb_dout, gb_din;
  logic [AW-1:0]      gb_addr;
  logic               gb_we, busy;

  logic [NREQ-1:0]    r3_valid, r3_we, r3_ready, r3_rv;
  logic [NREQ*AW-1:0] r3_addr;
  logic [NREQ*DW-1:0] r3_wdata;
  logic [DW-1:0]      r3_rdata, r3_dout, r3_din;
  logic [AW-1:0]      r3_gaddr;
  logic               r3_gwe, r3_busy;

  always #5 gb_clk = ~gb_clk;

  gb_host_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1), .PARK_ADDR(12'hFFF)) dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_din(gb_din),
    .busy(busy)
  );

  gb_host_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(3), .PARK_ADDR(12'hFFF)) dut3 (
    .gb_clk(gb_clk), .gb_rst(gb_rst),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_we(r3_we),
    .req_addr(r3_addr), .req_wdata(r3_wdata),
    .resp_valid(r3_rv), .resp_rdata(r3_rdata),
    .gb_addr(r3_gaddr), .gb_dout(r3_dout), .gb_we(r3_gwe), .gb_din(r3_din),
    .busy(r3_busy)
  );

  // One-cycle-latency memory slave.
  logic [DW-1:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h040] = 32'h1111_0040;
    mem[12'h041] = 32'h2222_0041;
  end
  always @(posedge gb_clk) begin
    if (gb_we) mem[gb_addr] <= gb_dout;
    gb_din <= mem[gb_addr];
  end

  // Three-cycle-latency slave answering only at 0x200.
  logic [DW-1:0] d1, d2, d3;
  always @(posedge gb_clk) begin
    d1 <= (r3_gaddr == 12'h200) ? 32'hDEAD_BEEF : 32'h0;
    d2 <= d1;
    d3 <= d2;
  end
  assign r3_din = d3;

  int cyc = 0;
  always @(posedge gb_clk) cyc <= cyc + 1;

  logic [NREQ-1:0] rdy_h [0:HM-1];
  logic [NREQ-1:0] rv_h  [0:HM-1];
  logic [DW-1:0]   rd_h  [0:HM-1];
  logic [AW-1:0]   ad_h  [0:HM-1];
  logic [DW-1:0]   do_h  [0:HM-1];
  logic            we_h  [0:HM-1];
  logic            bz_h  [0:HM-1];
  logic [NREQ-1:0] rdy3_h [0:HM-1];
  logic [NREQ-1:0] rv3_h  [0:HM-1];
  logic [DW-1:0]   rd3_h  [0:HM-1];
  logic [AW-1:0]   ad3_h  [0:HM-1];

  always @(negedge gb_clk) begin
    if (cyc < HM) begin
      rdy_h[cyc] <= req_ready;  rv_h[cyc] <= resp_valid; rd_h[cyc] <= resp_rdata;
      ad_h[cyc]  <= gb_addr;    do_h[cyc] <= gb_dout;    we_h[cyc] <= gb_we;
      bz_h[cyc]  <= busy;
      rdy3_h[cyc] <= r3_ready;  rv3_h[cyc] <= r3_rv;     rd3_h[cyc] <= r3_rdata;
      ad3_h[cyc]  <= r3_gaddr;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gb_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  int t;
  int we_seen;

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    r3_valid  = '0; r3_we  = '0; r3_addr  = '0; r3_wdata  = '0;

    gb_rst = 1'b1;
    repeat (3) step();
    gb_rst = 1'b0;

    // Idle after reset: parked, quiet.
    check("rst_rdata", resp_rdata, 0);
    check("rst_rv", resp_valid, 0);
    check("rst_rdata3", r3_rdata, 0);
    repeat (20) begin
      check("idle_park", {gb_addr, gb_we, busy, req_ready}, {12'hFFF, 1'b0, 1'b0, 2'b00});
      step();
    end

    // RD_LAT=3 read of 0x200.
    t = cyc;
    r3_valid[0] = 1'b1; r3_we[0] = 1'b0; r3_addr[AW-1:0] = 12'h200;
    step();
    r3_valid[0] = 1'b0;
    repeat (7) step();
    check("lat3_accept", rdy3_h[t], 2'b01);
    for (int k = 1; k <= 4; k++) check("lat3_addr_held", ad3_h[t+k], 12'h200);
    check("lat3_park", ad3_h[t+5], 12'hFFF);
    check("lat3_no_early_rv", rv3_h[t+4], 2'b00);
    check("lat3_rv", rv3_h[t+5], 2'b01);
    check("lat3_rdata", rd3_h[t+5], 32'hDEAD_BEEF);

    // Write 0x000 <- 0x42, then read it back, accept coinciding with write response.
    t = cyc;
    set_req(0, 1'b1, 1'b1, 12'h000, 32'h42);
    step();
    set_req(0, 1'b0, 1'b0, 12'h000, 32'h0);
    step();
    set_req(0, 1'b1, 1'b0, 12'h000, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 12'h000, 32'h0);
    repeat (5) step();
    check("wr_accept", rdy_h[t], 2'b01);
    check("wr_we", we_h[t+1], 1'b1);
    check("wr_addr", ad_h[t+1], 12'h000);
    check("wr_dout", do_h[t+1], 32'h42);
    check("wr_we_off", we_h[t+2], 1'b0);
    check("wr_park", ad_h[t+2], 12'hFFF);
    check("wr_no_early_rv", rv_h[t+1], 2'b00);
    check("wr_rv", rv_h[t+2], 2'b01);
    check("wr_rdata_kept", rd_h[t+2], 32'h0);
    check("rb_accept", rdy_h[t+2], 2'b01);
    check("rb_we", {we_h[t+3], we_h[t+4]}, 2'b00);
    check("rb_addr0", ad_h[t+3], 12'h000);
    check("rb_addr1", ad_h[t+4], 12'h000);
    check("rb_no_early_rv", rv_h[t+4], 2'b00);
    check("rb_rv", rv_h[t+5], 2'b01);
    check("rb_rdata", rd_h[t+5], 32'h42);

    // Reset, then both requesters reading continuously.
    gb_rst = 1'b1;
    step();
    gb_rst = 1'b0;
    t = cyc;
    set_req(0, 1'b1, 1'b0, 12'h040, 32'h0);
    set_req(1, 1'b1, 1'b0, 12'h041, 32'h0);
    repeat (18) step();
    set_req(0, 1'b0, 1'b0, 12'h040, 32'h0);
    set_req(1, 1'b0, 1'b0, 12'h041, 32'h0);
    repeat (6) step();
    for (int k = 0; k < 6; k++) begin
      logic [1:0]  oh;
      logic [11:0] ea;
      logic [31:0] ed;
      oh = (k % 2 == 1) ? 2'b10 : 2'b01;
      ea = (k % 2 == 1) ? 12'h041 : 12'h040;
      ed = (k % 2 == 1) ? 32'h2222_0041 : 32'h1111_0040;
      check("rr_accept", rdy_h[t+3*k], oh);
      check("rr_addr0", ad_h[t+3*k+1], ea);
      check("rr_addr1", ad_h[t+3*k+2], ea);
      check("rr_rv", rv_h[t+3*k+3], oh);
      check("rr_rdata", rd_h[t+3*k+3], ed);
    end
    we_seen = 0;
    for (int k = 0; k < 21; k++) if (we_h[t+k]) we_seen++;
    check("rr_no_we", we_seen, 0);

    // Reset during req1's read cycle.
    t = cyc;
    set_req(1, 1'b1, 1'b0, 12'h041, 32'h0);
    step();
    set_req(1, 1'b0, 1'b0, 12'h041, 32'h0);
    gb_rst = 1'b1;
    step();
    gb_rst = 1'b0;
    check("rst_mid_addr", gb_addr, 12'hFFF);
    check("rst_mid_busy", busy, 1'b0);
    step();
    set_req(0, 1'b1, 1'b0, 12'h040, 32'h0);
    set_req(1, 1'b1, 1'b0, 12'h041, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 12'h040, 32'h0);
    set_req(1, 1'b0, 1'b0, 12'h041, 32'h0);
    repeat (6) step();
    check("rst_mid_accept1", rdy_h[t], 2'b10);
    check("rst_mid_rd_addr", ad_h[t+1], 12'h041);
    check("rst_mid_no_rv", {rv_h[t+1], rv_h[t+2], rv_h[t+3], rv_h[t+4], rv_h[t+5]}, 10'h0);
    check("rst_mid_next_grant", rdy_h[t+3], 2'b01);
    check("rst_mid_rv0", rv_h[t+6], 2'b01);
    check("rst_mid_rdata0", rd_h[t+6], 32'h1111_0040);

    // Req1 pulses req_valid for one cycle while req0 reads.
    t = cyc;
    set_req(0, 1'b1, 1'b0, 12'h041, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 12'h041, 32'h0);
    set_req(1, 1'b1, 1'b0, 12'h040, 32'h0);
    step();
    set_req(1, 1'b0, 1'b0, 12'h040, 32'h0);
    repeat (8) step();
    check("glitch_accept0", rdy_h[t], 2'b01);
    check("glitch_no_rdy", {rdy_h[t+1], rdy_h[t+2]}, 4'h0);
    check("glitch_rv0", rv_h[t+3], 2'b01);
    check("glitch_rdata0", rd_h[t+3], 32'h2222_0041);
    for (int k = 3; k <= 8; k++) begin
      check("glitch_quiet_rdy", rdy_h[t+k], 2'b00);
      check("glitch_park", ad_h[t+k], 12'hFFF);
      if (k > 3) check("glitch_quiet_rv", rv_h[t+k], 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
